rv32i_controller: RTL and testbench
===================================

Name: rv32i_controller

Overview:
- Main decode controller for the RV32I core's decode stage: maps opcode/funct3/funct7 to datapath control signals (register write, memory write, writeback select, ALU op and operand selects, branch/jump flags, memory access size).
- Outputs are registered, forming the decode→execute control register, so control lags the instruction fields by one clock.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- opcode  input  7  instruction[6:0]
- f3  input  3  instruction funct3
- f7  input  7  instruction funct7
- regWR  output  1  register file write enable
- memWR  output  1  data memory write enable
- wbCtrl  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate
- aluOp  output  4  ALU operation (encoding below)
- aluS1  output  1  ALU operand A: 0 rs1, 1 PC
- aluS2  output  1  ALU operand B: 0 rs2, 1 immediate
- branchCtrl  output  3  branch condition, equals f3 for valid branches, else 000
- memCtrl  output  3  load/store size/sign, equals f3 for valid loads/stores, else 000
- doBranch  output  1  conditional branch instruction
- doJump  output  1  unconditional jump (JAL/JALR)

Behaviour:
- Combinational decode feeds one output register; every output updates on each rising clk edge. Latency is exactly 1 cycle and there is no handshake.
- Reset: while rst_n=0 at a rising edge, all outputs clear to 0, which is the NOP encoding.
- NOP (all outputs 0) is produced for any unknown opcode or any invalid funct combination.
- aluOp encoding:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
  - For arithmetic instructions, aluOp = {f7[5], f3}.
- R-type (0110011):
  - regWR=1, wbCtrl=00, aluS1=0, aluS2=0, aluOp={f7[5],f3}.
  - f7 must be 0000000, or 0100000 only with f3=000 or 101; any other f7 gives NOP.
- I-ALU (0010011):
  - regWR=1, wbCtrl=00, aluS2=1.
  - aluOp={0,f3}, except f3=101 gives aluOp={f7[5],101}.
  - f3=001 requires f7=0000000; f3=101 requires f7 of 0000000 or 0100000; otherwise NOP.
  - f7 is ignored for all other f3 values (ADDI never becomes SUB).
- Load (0000011):
  - regWR=1, wbCtrl=01, aluS2=1, aluOp=ADD, memCtrl=f3.
  - Valid f3 are 000, 001, 010, 100, 101; any other f3 gives NOP.
- Store (0100011):
  - memWR=1, regWR=0, aluS2=1, aluOp=ADD, memCtrl=f3.
  - Valid f3 are 000, 001, 010; any other f3 gives NOP.
- Branch (1100011):
  - doBranch=1, regWR=0, aluS1=1, aluS2=1, aluOp=ADD (target), branchCtrl=f3.
  - f3 of 010 or 011 gives NOP.
- LUI (0110111): regWR=1, wbCtrl=11, aluS2=1, aluOp=ADD. f3 and f7 are ignored.
- AUIPC (0010111): regWR=1, wbCtrl=00, aluS1=1, aluS2=1, aluOp=ADD. f3 and f7 are ignored.
- JAL (1101111): regWR=1, wbCtrl=10, doJump=1, aluS1=1, aluS2=1, aluOp=ADD. f3 is ignored.
- JALR (1100111): regWR=1, wbCtrl=10, doJump=1, aluS1=0, aluS2=1, aluOp=ADD. Requires f3=000, else NOP.
- Invariants:
  - doBranch and doJump are never both 1.
  - memWR=1 implies regWR=0.
  - Fields not listed for an opcode are 0.
- Reset asserted mid-stream overrides decode for that edge. The first edge after rst_n returns high registers the decode of the current inputs.

Optional Feature:
- Macro CTRL_ILLEGAL_DETECT_EN.
- When defined:
  - Adds output illegal (1 bit), registered with the other outputs and reset to 0.
  - illegal=1 in the cycle after any input combination that decodes to NOP because of an unknown opcode or invalid funct3/funct7.
- When undefined: the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with opcode=0110011 → all outputs 0. Release → next edge gives regWR=1.
- R-type, opcode 0110011:
  - f3=000, f7=0100000 → aluOp=1000, regWR=1, aluS2=0.
  - f3=101, f7=0100000 → aluOp=1101.
  - f3=001, f7=0100000 → NOP.
- I-ALU, opcode 0010011:
  - f3=000, f7=0100000 → aluOp=0000, aluS2=1.
  - f3=101, f7=0100000 → aluOp=1101.
- Load/store:
  - opcode 0000011 with f3=100 → memCtrl=100, wbCtrl=01, regWR=1.
  - opcode 0100011 with f3=010 → memWR=1, regWR=0, memCtrl=010.
  - opcode 0100011 with f3=011 → NOP.
- Control flow:
  - opcode 1100011 with f3=101 → doBranch=1, branchCtrl=101, aluS1=1.
  - opcode 1101111 → doJump=1, wbCtrl=10.
  - opcode 1100111 with f3=001 → NOP.
- Others and timing:
  - opcode 0110111 → wbCtrl=11, regWR=1.
  - opcode 0010111 → aluS1=1, wbCtrl=00.
  - opcode 0011111 → NOP.
  - Every output change appears exactly one edge after the input change.

Source files
------------

// File: rtl/rv32i_controller.sv
// ---------------------------------------------------------------------------
// rv32i_controller
//
// Main decode controller for the RV32I decode stage. It turns the opcode,
// funct3 and funct7 fields of the current instruction into datapath control
// signals. The decode logic is purely combinational. Its result is captured in
// a single output register, which forms the decode->execute control register.
// As a result, every output lags the instruction fields by exactly one clock.
//
// There is no handshake. A new decode is registered on every rising edge.
//
// Any unknown opcode or illegal funct3/funct7 combination decodes to NOP.
// NOP is the all-zero control word, which is also the reset value.
//
// Optional feature (macro CTRL_ILLEGAL_DETECT_EN):
//   Adds the 1-bit output "illegal". It is registered alongside the other
//   outputs and resets to 0. It is 1 in the cycle after an input combination
//   that decoded to NOP because it is not a legal instruction.
//
// Ports:
//   clk        in   1  system clock, rising-edge active
//   rst_n      in   1  synchronous active-low reset
//   opcode     in   7  instruction[6:0]
//   f3         in   3  funct3
//   f7         in   7  funct7
//   regWR      out  1  register file write enable
//   memWR      out  1  data memory write enable
//   wbCtrl     out  2  writeback select: 00 ALU, 01 mem, 10 PC+4, 11 imm
//   aluOp      out  4  ALU operation
//   aluS1      out  1  ALU operand A select: 0 rs1, 1 PC
//   aluS2      out  1  ALU operand B select: 0 rs2, 1 immediate
//   branchCtrl out  3  branch condition (funct3 of a valid branch)
//   memCtrl    out  3  load/store size and sign (funct3 of a valid ld/st)
//   doBranch   out  1  conditional branch
//   doJump     out  1  unconditional jump (JAL/JALR)
//   illegal    out  1  only with CTRL_ILLEGAL_DETECT_EN
// ---------------------------------------------------------------------------
module rv32i_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic       regWR,
    output logic       memWR,
    output logic [1:0] wbCtrl,
    output logic [3:0] aluOp,
    output logic       aluS1,
    output logic       aluS2,
    output logic [2:0] branchCtrl,
    output logic [2:0] memCtrl,
    output logic       doBranch,
    output logic       doJump
`ifdef CTRL_ILLEGAL_DETECT_EN
    ,
    output logic       illegal
`endif
);

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct7 values that RV32I accepts
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Writeback select encodings
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // ALU op used for address and target computation
    localparam logic [3:0] ALU_ADD = 4'b0000;

    // funct3 values that carry special meaning in the ALU groups
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // ------------------------------------------------------------------
    // Raw decode: fields as the opcode group would drive them, plus a
    // separate legality flag. Squashing to NOP is a second step, so each
    // opcode group only needs to say whether its funct fields are legal.
    // ------------------------------------------------------------------
    logic       raw_regwr;
    logic       raw_memwr;
    logic [1:0] raw_wb;
    logic [3:0] raw_aluop;
    logic       raw_alus1;
    logic       raw_alus2;
    logic [2:0] raw_brctrl;
    logic [2:0] raw_memctrl;
    logic       raw_dobranch;
    logic       raw_dojump;
    logic       legal;

    always_comb begin
        raw_regwr    = 1'b0;
        raw_memwr    = 1'b0;
        raw_wb       = WB_ALU;
        raw_aluop    = ALU_ADD;
        raw_alus1    = 1'b0;
        raw_alus2    = 1'b0;
        raw_brctrl   = 3'b000;
        raw_memctrl  = 3'b000;
        raw_dobranch = 1'b0;
        raw_dojump   = 1'b0;
        legal        = 1'b0;

        case (opcode)
            OP_R: begin
                // The alternate funct7 exists only for SUB and SRA.
                legal     = (f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
                raw_regwr = 1'b1;
                raw_wb    = WB_ALU;
                raw_aluop = {f7[5], f3};
            end

            OP_I_ALU: begin
                // f7 acts as part of the immediate, except for shifts. For
                // those, it distinguishes SRLI from SRAI or must be zero.
                // ADDI ignores f7[5], so it never turns into SUB.
                case (f3)
                    F3_SLL:     legal = (f7 == F7_BASE);
                    F3_SRL_SRA: legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    default:    legal = 1'b1;
                endcase
                raw_regwr = 1'b1;
                raw_wb    = WB_ALU;
                raw_alus2 = 1'b1;
                raw_aluop = (f3 == F3_SRL_SRA) ? {f7[5], f3} : {1'b0, f3};
            end

            OP_LOAD: begin
                // LB, LH, LW, LBU, LHU
                legal       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                              (f3 == 3'b100) || (f3 == 3'b101);
                raw_regwr   = 1'b1;
                raw_wb      = WB_MEM;
                raw_alus2   = 1'b1;
                raw_aluop   = ALU_ADD;
                raw_memctrl = f3;
            end

            OP_STORE: begin
                // SB, SH, SW
                legal       = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                raw_memwr   = 1'b1;
                raw_alus2   = 1'b1;
                raw_aluop   = ALU_ADD;
                raw_memctrl = f3;
            end

            OP_BRANCH: begin
                // The ALU computes the target PC+imm. The comparator uses
                // branchCtrl. funct3 010 and 011 are unassigned.
                legal        = (f3 != 3'b010) && (f3 != 3'b011);
                raw_dobranch = 1'b1;
                raw_alus1    = 1'b1;
                raw_alus2    = 1'b1;
                raw_aluop    = ALU_ADD;
                raw_brctrl   = f3;
            end

            OP_LUI: begin
                legal     = 1'b1;
                raw_regwr = 1'b1;
                raw_wb    = WB_IMM;
                raw_alus2 = 1'b1;
                raw_aluop = ALU_ADD;
            end

            OP_AUIPC: begin
                legal     = 1'b1;
                raw_regwr = 1'b1;
                raw_wb    = WB_ALU;
                raw_alus1 = 1'b1;
                raw_alus2 = 1'b1;
                raw_aluop = ALU_ADD;
            end

            OP_JAL: begin
                legal      = 1'b1;
                raw_regwr  = 1'b1;
                raw_wb     = WB_PC4;
                raw_dojump = 1'b1;
                raw_alus1  = 1'b1;
                raw_alus2  = 1'b1;
                raw_aluop  = ALU_ADD;
            end

            OP_JALR: begin
                // The target is rs1+imm, so operand A stays on rs1.
                legal      = (f3 == 3'b000);
                raw_regwr  = 1'b1;
                raw_wb     = WB_PC4;
                raw_dojump = 1'b1;
                raw_alus1  = 1'b0;
                raw_alus2  = 1'b1;
                raw_aluop  = ALU_ADD;
            end

            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // NOP squash: an illegal decode drives the all-zero control word.
    // ------------------------------------------------------------------
    logic       regwr_d,    regwr_q;
    logic       memwr_d,    memwr_q;
    logic [1:0] wb_d,       wb_q;
    logic [3:0] aluop_d,    aluop_q;
    logic       alus1_d,    alus1_q;
    logic       alus2_d,    alus2_q;
    logic [2:0] brctrl_d,   brctrl_q;
    logic [2:0] memctrl_d,  memctrl_q;
    logic       dobranch_d, dobranch_q;
    logic       dojump_d,   dojump_q;

    always_comb begin
        regwr_d    = legal & raw_regwr;
        memwr_d    = legal & raw_memwr;
        wb_d       = legal ? raw_wb      : 2'b00;
        aluop_d    = legal ? raw_aluop   : 4'b0000;
        alus1_d    = legal & raw_alus1;
        alus2_d    = legal & raw_alus2;
        brctrl_d   = legal ? raw_brctrl  : 3'b000;
        memctrl_d  = legal ? raw_memctrl : 3'b000;
        dobranch_d = legal & raw_dobranch;
        dojump_d   = legal & raw_dojump;
    end

    // ------------------------------------------------------------------
    // Decode->execute control register. Reset takes priority over the
    // decode on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwr_q    <= 1'b0;
            memwr_q    <= 1'b0;
            wb_q       <= 2'b00;
            aluop_q    <= 4'b0000;
            alus1_q    <= 1'b0;
            alus2_q    <= 1'b0;
            brctrl_q   <= 3'b000;
            memctrl_q  <= 3'b000;
            dobranch_q <= 1'b0;
            dojump_q   <= 1'b0;
        end else begin
            regwr_q    <= regwr_d;
            memwr_q    <= memwr_d;
            wb_q       <= wb_d;
            aluop_q    <= aluop_d;
            alus1_q    <= alus1_d;
            alus2_q    <= alus2_d;
            brctrl_q   <= brctrl_d;
            memctrl_q  <= memctrl_d;
            dobranch_q <= dobranch_d;
            dojump_q   <= dojump_d;
        end
    end

    assign regWR      = regwr_q;
    assign memWR      = memwr_q;
    assign wbCtrl     = wb_q;
    assign aluOp      = aluop_q;
    assign aluS1      = alus1_q;
    assign aluS2      = alus2_q;
    assign branchCtrl = brctrl_q;
    assign memCtrl    = memctrl_q;
    assign doBranch   = dobranch_q;
    assign doJump     = dojump_q;

`ifdef CTRL_ILLEGAL_DETECT_EN
    logic illegal_d, illegal_q;

    assign illegal_d = ~legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_rv32i_controller.sv
// ---------------------------------------------------------------------------
// tb_rv32i_controller
//
// Randomized and directed bench for rv32i_controller. Inputs are driven on
// the falling edge. The expected control word for each drive is computed by
// a rule-level reference model and pushed into exp_q. It is popped and
// compared 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_rv32i_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       regWR;
  logic       memWR;
  logic [1:0] wbCtrl;
  logic [3:0] aluOp;
  logic       aluS1;
  logic       aluS2;
  logic [2:0] branchCtrl;
  logic [2:0] memCtrl;
  logic       doBranch;
  logic       doJump;
`ifdef CTRL_ILLEGAL_DETECT_EN
  logic       illegal;
`endif

  int n_cmp;
  int n_err;

  // Bit 18 is the illegal flag; bits 17:0 are the control word.
  logic [18:0] exp_q[$];
  logic [18:0] last_exp;

  rv32i_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .f3         (f3),
    .f7         (f7),
    .regWR      (regWR),
    .memWR      (memWR),
    .wbCtrl     (wbCtrl),
    .aluOp      (aluOp),
    .aluS1      (aluS1),
    .aluS2      (aluS2),
    .branchCtrl (branchCtrl),
    .memCtrl    (memCtrl),
    .doBranch   (doBranch),
    .doJump     (doJump)
`ifdef CTRL_ILLEGAL_DETECT_EN
    ,
    .illegal    (illegal)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_word();
    return {regWR, memWR, wbCtrl, aluOp, aluS1, aluS2, branchCtrl, memCtrl, doBranch, doJump};
  endfunction

  // ---------------- reference model ----------------
  // Derived from the instruction set rules: first decide whether the
  // instruction exists, then list the control fields that it sets.
  function automatic logic [18:0] ref_model(input logic rst, input logic [6:0] op,
                                            input logic [2:0] fn3, input logic [6:0] fn7);
    logic       ok;
    logic       rw, mw, s1, s2, br, jp;
    logic [1:0] wb;
    logic [3:0] alu;
    logic [2:0] bc, mc;
    if (!rst) return 19'd0;
    rw = 0; mw = 0; s1 = 0; s2 = 0; br = 0; jp = 0;
    wb = 0; alu = 0; bc = 0; mc = 0; ok = 0;
    case (op)
      7'h33: begin
        ok  = (fn7 == 7'h00) || (fn7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5));
        rw  = 1;
        alu = {fn7[5], fn3};
      end
      7'h13: begin
        if (fn3 == 3'd1)      ok = (fn7 == 7'h00);
        else if (fn3 == 3'd5) ok = (fn7 == 7'h00 || fn7 == 7'h20);
        else                  ok = 1;
        rw  = 1;
        s2  = 1;
        alu = (fn3 == 3'd5) ? {fn7[5], fn3} : {1'b0, fn3};
      end
      7'h03: begin
        ok = (fn3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        rw = 1; wb = 2'd1; s2 = 1; mc = fn3;
      end
      7'h23: begin
        ok = (fn3 <= 3'd2);
        mw = 1; s2 = 1; mc = fn3;
      end
      7'h63: begin
        ok = !(fn3 inside {3'd2, 3'd3});
        br = 1; s1 = 1; s2 = 1; bc = fn3;
      end
      7'h37: begin ok = 1; rw = 1; wb = 2'd3; s2 = 1; end
      7'h17: begin ok = 1; rw = 1; s1 = 1; s2 = 1; end
      7'h6f: begin ok = 1; rw = 1; wb = 2'd2; jp = 1; s1 = 1; s2 = 1; end
      7'h67: begin ok = (fn3 == 3'd0); rw = 1; wb = 2'd2; jp = 1; s2 = 1; end
      default: ok = 0;
    endcase
    if (!ok) return {1'b1, 18'd0};
    return {1'b0, rw, mw, wb, alu, s1, s2, bc, mc, br, jp};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs and checks the registered result. If
  // check_hold is set, it also verifies that the outputs still show the
  // previous decode before the edge.
  task automatic drive_step(input string tag, input logic rst, input logic [6:0] op,
                            input logic [2:0] fn3, input logic [6:0] fn7, input bit check_hold);
    logic [18:0] e;
    @(negedge clk);
    rst_n  = rst;
    opcode = op;
    f3     = fn3;
    f7     = fn7;
    exp_q.push_back(ref_model(rst, op, fn3, fn7));
    if (check_hold) begin
      #1;
      check_val({tag, "_hold"}, {14'd0, dut_word()}, {14'd0, last_exp[17:0]});
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_exp = e;
    check_val(tag, {14'd0, dut_word()}, {14'd0, e[17:0]});
`ifdef CTRL_ILLEGAL_DETECT_EN
    check_val({tag, "_ill"}, {31'd0, illegal}, {31'd0, e[18]});
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    opcode   = 7'b0110011;
    f3       = 3'd0;
    f7       = 7'd0;

    // Reset held for two edges with an R-type opcode presented.
    drive_step("rst0", 1'b0, 7'b0110011, 3'd0, 7'h00, 1'b0);
    drive_step("rst1", 1'b0, 7'b0110011, 3'd0, 7'h00, 1'b0);
    check_val("rst_word", {14'd0, dut_word()}, 32'd0);
    drive_step("rst_rel", 1'b1, 7'b0110011, 3'd0, 7'h00, 1'b1);
    check_val("rst_rel_regwr", {31'd0, regWR}, 32'd1);

    // Directed cases with explicit field checks.
    drive_step("r_sub", 1'b1, 7'b0110011, 3'b000, 7'b0100000, 1'b1);
    check_val("r_sub_aluop", {28'd0, aluOp}, 32'b1000);
    check_val("r_sub_alus2", {31'd0, aluS2}, 32'd0);
    drive_step("r_sra", 1'b1, 7'b0110011, 3'b101, 7'b0100000, 1'b1);
    check_val("r_sra_aluop", {28'd0, aluOp}, 32'b1101);
    drive_step("r_bad", 1'b1, 7'b0110011, 3'b001, 7'b0100000, 1'b1);
    check_val("r_bad_nop", {14'd0, dut_word()}, 32'd0);
    drive_step("i_addi", 1'b1, 7'b0010011, 3'b000, 7'b0100000, 1'b1);
    check_val("i_addi_aluop", {28'd0, aluOp}, 32'b0000);
    check_val("i_addi_alus2", {31'd0, aluS2}, 32'd1);
    drive_step("i_srai", 1'b1, 7'b0010011, 3'b101, 7'b0100000, 1'b1);
    check_val("i_srai_aluop", {28'd0, aluOp}, 32'b1101);
    drive_step("ld_lbu", 1'b1, 7'b0000011, 3'b100, 7'h00, 1'b1);
    check_val("ld_lbu_fields", {26'd0, memCtrl, wbCtrl, regWR}, {26'd0, 3'b100, 2'b01, 1'b1});
    drive_step("st_sw", 1'b1, 7'b0100011, 3'b010, 7'h00, 1'b1);
    check_val("st_sw_fields", {27'd0, memWR, regWR, memCtrl}, {27'd0, 1'b1, 1'b0, 3'b010});
    drive_step("st_bad", 1'b1, 7'b0100011, 3'b011, 7'h00, 1'b1);
    check_val("st_bad_nop", {14'd0, dut_word()}, 32'd0);
    drive_step("br_bge", 1'b1, 7'b1100011, 3'b101, 7'h00, 1'b1);
    check_val("br_bge_fields", {27'd0, doBranch, branchCtrl, aluS1}, {27'd0, 1'b1, 3'b101, 1'b1});
    drive_step("jal", 1'b1, 7'b1101111, 3'b110, 7'h15, 1'b1);
    check_val("jal_fields", {29'd0, doJump, wbCtrl}, {29'd0, 1'b1, 2'b10});
    drive_step("jalr_bad", 1'b1, 7'b1100111, 3'b001, 7'h00, 1'b1);
    check_val("jalr_bad_nop", {14'd0, dut_word()}, 32'd0);
    drive_step("lui", 1'b1, 7'b0110111, 3'b011, 7'h7f, 1'b1);
    check_val("lui_fields", {29'd0, wbCtrl, regWR}, {29'd0, 2'b11, 1'b1});
    drive_step("auipc", 1'b1, 7'b0010111, 3'b000, 7'h00, 1'b1);
    check_val("auipc_fields", {29'd0, aluS1, wbCtrl}, {29'd0, 1'b1, 2'b00});
    drive_step("unk_op", 1'b1, 7'b0011111, 3'b000, 7'h00, 1'b1);
    check_val("unk_op_nop", {14'd0, dut_word()}, 32'd0);
    // Reset mid-stream overrides a legal decode.
    drive_step("rst_mid", 1'b0, 7'b1101111, 3'b000, 7'h00, 1'b1);
    drive_step("rst_mid_rel", 1'b1, 7'b0100011, 3'b000, 7'h00, 1'b1);

    // Randomized stream, biased toward legal opcodes and meaningful f7.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      logic [6:0] fn7;
      logic       rst;
      int         sel;
      op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      sel = $urandom_range(0, 3);
      fn7 = (sel == 0) ? 7'h20 : (sel == 1) ? 7'($urandom) : 7'h00;
      rst = ($urandom_range(0, 49) != 0);
      drive_step("rand", rst, op, 3'($urandom), fn7, (i % 4) == 0);
      check_val("inv_br_jmp", {31'd0, doBranch & doJump}, 32'd0);
      check_val("inv_mw_rw", {31'd0, memWR & regWR}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the stimulus is bounded, but keep any stall from hanging.
  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
